// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared register map, status codes, CCR layout and sequencer states
//
// No ports. Imported by qspi_xip_sequencer and qspi_xip_line_buf.
//   QSPI_CCR/ADR/DR/STA : QSPI master register byte offsets
//   STA_IDLE/STA_CMD    : values read back from STA
//   CCR_*               : CCR field bit positions
//   seq_state_e         : XIP sequencer FSM states
//   ccr_word()          : packs a CCR value with start=1 and write=0
package qspi_pkg;

  localparam logic [5:0] QSPI_CCR = 6'd0;
  localparam logic [5:0] QSPI_ADR = 6'd4;
  localparam logic [5:0] QSPI_DR  = 6'd8;
  localparam logic [5:0] QSPI_STA = 6'd40;

  localparam logic [31:0] STA_IDLE = 32'd1;
  localparam logic [31:0] STA_CMD  = 32'd2;

  localparam int CCR_INSTR_LSB = 0;
  localparam int CCR_MODE_LSB  = 8;
  localparam int CCR_WRITE_BIT = 10;
  localparam int CCR_DUMMY_LSB = 11;
  localparam int CCR_SIZE_LSB  = 16;
  localparam int CCR_PRESC_LSB = 25;
  localparam int CCR_START_BIT = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADR,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_FETCH,
    ST_RESP
  } seq_state_e;

  function automatic logic [31:0] ccr_word(
    input logic [7:0] instr,
    input logic [1:0] mode,
    input logic [4:0] dummy,
    input logic [4:0] size_m1,
    input logic [5:0] presc
  );
    logic [31:0] w;
    w = '0;
    w[CCR_INSTR_LSB +: 8] = instr;
    w[CCR_MODE_LSB  +: 2] = mode;
    w[CCR_WRITE_BIT]      = 1'b0;
    w[CCR_DUMMY_LSB +: 5] = dummy;
    w[CCR_SIZE_LSB  +: 5] = size_m1;
    w[CCR_PRESC_LSB +: 6] = presc;
    w[CCR_START_BIT]      = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/qspi_xip_line_buf.sv
// rtl/qspi_xip_line_buf.sv - single 32-byte XIP line buffer with tag, valid and hit compare
//
// Ports:
//   clk_i, rst_ni       : clock, asynchronous active-low reset (clears valid)
//   lookup_tag_i        : addr[23:5] of the incoming request
//   rd_idx_i            : word index addr[4:2] for the hit read
//   hit_o               : line valid and tag matches
//   rd_data_o           : stored word at rd_idx_i
//   wr_en_i/wr_idx_i/wr_data_i : line fill word write
//   fill_i, fill_tag_i  : line fill complete, mark valid with this tag
//   inval_i             : drop the line (has priority over fill_i)
module qspi_xip_line_buf
  import qspi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [18:0] lookup_tag_i,
  input  logic [2:0]  rd_idx_i,
  output logic        hit_o,
  output logic [31:0] rd_data_o,
  input  logic        wr_en_i,
  input  logic [2:0]  wr_idx_i,
  input  logic [31:0] wr_data_i,
  input  logic        fill_i,
  input  logic [18:0] fill_tag_i,
  input  logic        inval_i
);

  logic [7:0][31:0] mem_q, mem_d;
  logic [18:0]      tag_q, tag_d;
  logic             valid_q, valid_d;

  always_comb begin
    mem_d   = mem_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (wr_en_i) begin
      mem_d[wr_idx_i] = wr_data_i;
    end
    if (inval_i) begin
      valid_d = 1'b0;
    end else if (fill_i) begin
      valid_d = 1'b1;
      tag_d   = fill_tag_i;
    end
  end

  // Data storage needs no reset: it is only read behind a valid tag.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

  assign hit_o     = valid_q && (tag_q == lookup_tag_i);
  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/qspi_xip_sequencer.sv
// rtl/qspi_xip_sequencer.sv - XIP word-read sequencer driving QSPI master registers
//
// Optional feature macro: QSPI_XIP_CACHE_EN (adds a one-line 32-byte buffer).
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   req_i, addr_i        : word read request and byte address (bits [1:0] ignored)
//   gnt_o                : request accepted this cycle
//   rvalid_o, rdata_o    : one-cycle response pulse and returned word
//   err_o                : timeout flag, pulses with rvalid_o
//   busy_o               : sequencer not idle
//   qspi_write_o, qspi_be_o, qspi_addr_o, qspi_wdata_o : master register access
//   qspi_rdata_i         : master read data, one cycle after qspi_addr_o
module qspi_xip_sequencer
  import qspi_pkg::*;
#(
  parameter logic [7:0] READ_CMD    = 8'h6B,
  parameter logic [1:0] DATA_MODE   = 2'b11,
  parameter int         DUMMY_BYTES = 4,
  parameter logic [5:0] PRESCALER   = 6'd1,
  parameter int         TIMEOUT     = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [23:0] addr_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        qspi_write_o,
  output logic [3:0]  qspi_be_o,
  output logic [5:0]  qspi_addr_o,
  output logic [31:0] qspi_wdata_o,
  input  logic [31:0] qspi_rdata_i
);

`ifdef QSPI_XIP_CACHE_EN
  localparam logic [3:0] FETCH_WORDS = 4'd8;
  localparam logic [4:0] SIZE_M1     = 5'd31;
`else
  localparam logic [3:0] FETCH_WORDS = 4'd1;
  localparam logic [4:0] SIZE_M1     = 5'd3;
`endif
  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam logic [31:0] CCR_VAL = ccr_word(READ_CMD, DATA_MODE, 5'(DUMMY_BYTES),
                                             SIZE_M1, PRESCALER);

  seq_state_e    state_q, state_d;
  logic [23:0]   addr_q, addr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    fetch_q, fetch_d;
  logic          sta_skip_q, sta_skip_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          timeout;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^addr_i[1:0];
  assign timeout          = (tmo_q == TW'(TIMEOUT - 1));

`ifdef QSPI_XIP_CACHE_EN
  logic [2:0]  word_q, word_d;
  logic        lb_hit, lb_wr_en, lb_fill, lb_inval;
  logic [2:0]  lb_wr_idx;
  logic [31:0] lb_rd_data;

  // Data for DR offset k arrives while fetch_q == k+1.
  assign lb_wr_idx = fetch_q[2:0] - 3'd1;

  qspi_xip_line_buf u_line_buf (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .lookup_tag_i (addr_i[23:5]),
    .rd_idx_i     (addr_i[4:2]),
    .hit_o        (lb_hit),
    .rd_data_o    (lb_rd_data),
    .wr_en_i      (lb_wr_en),
    .wr_idx_i     (lb_wr_idx),
    .wr_data_i    (qspi_rdata_i),
    .fill_i       (lb_fill),
    .fill_tag_i   (addr_q[23:5]),
    .inval_i      (lb_inval)
  );
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tmo_d        = tmo_q;
    fetch_d      = fetch_q;
    sta_skip_d   = sta_skip_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    gnt_o        = 1'b0;
    rvalid_o     = 1'b0;
    err_o        = 1'b0;
    qspi_write_o = 1'b0;
    qspi_be_o    = 4'h0;
    qspi_addr_o  = 6'd0;
    qspi_wdata_o = 32'h0;
`ifdef QSPI_XIP_CACHE_EN
    word_d       = word_q;
    lb_wr_en     = 1'b0;
    lb_fill      = 1'b0;
    lb_inval     = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // State flops hold IDLE during reset, so gate the grant explicitly.
        gnt_o = req_i && rst_ni;
        if (req_i) begin
`ifdef QSPI_XIP_CACHE_EN
          word_d = addr_i[4:2];
          if (lb_hit) begin
            rdata_d = lb_rd_data;
            err_d   = 1'b0;
            state_d = ST_RESP;
          end else begin
            // The refill overwrites the buffer, so the old line is gone now.
            addr_d   = {addr_i[23:5], 5'b0};
            lb_inval = 1'b1;
            state_d  = ST_ADR;
          end
`else
          addr_d  = {addr_i[23:2], 2'b0};
          state_d = ST_ADR;
`endif
        end
      end

      ST_ADR: begin
        qspi_write_o = 1'b1;
        qspi_be_o    = 4'hF;
        qspi_addr_o  = QSPI_ADR;
        qspi_wdata_o = {addr_q[7:0], addr_q[15:8], addr_q[23:16], 8'h00};
        state_d      = ST_START;
      end

      ST_START: begin
        qspi_write_o = 1'b1;
        qspi_be_o    = 4'hF;
        qspi_addr_o  = QSPI_CCR;
        qspi_wdata_o = CCR_VAL;
        tmo_d        = '0;
        sta_skip_d   = 1'b1;
        state_d      = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        qspi_addr_o = QSPI_STA;
        sta_skip_d  = 1'b0;
        if (timeout) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = ST_RESP;
`ifdef QSPI_XIP_CACHE_EN
          lb_inval = 1'b1;
`endif
        end else begin
          tmo_d = tmo_q + TW'(1);
          // First data after entering a wait state belongs to the previous address.
          if (!sta_skip_q) begin
            if (state_q == ST_WAIT_BUSY && qspi_rdata_i != STA_IDLE) begin
              state_d    = ST_WAIT_DONE;
              sta_skip_d = 1'b1;
            end else if (state_q == ST_WAIT_DONE && qspi_rdata_i == STA_IDLE) begin
              fetch_d = 4'd0;
              state_d = ST_FETCH;
            end
          end
        end
      end

      ST_FETCH: begin
        if (fetch_q < FETCH_WORDS) begin
          qspi_addr_o = QSPI_DR + {1'b0, fetch_q[2:0], 2'b00};
        end
        if (fetch_q != 4'd0) begin
`ifdef QSPI_XIP_CACHE_EN
          lb_wr_en = 1'b1;
          if (lb_wr_idx == word_q) begin
            rdata_d = qspi_rdata_i;
          end
`else
          rdata_d = qspi_rdata_i;
`endif
        end
        if (fetch_q == FETCH_WORDS) begin
          err_d   = 1'b0;
          state_d = ST_RESP;
`ifdef QSPI_XIP_CACHE_EN
          lb_fill = 1'b1;
`endif
        end else begin
          fetch_d = fetch_q + 4'd1;
        end
      end

      ST_RESP: begin
        rvalid_o = 1'b1;
        err_o    = err_q;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      tmo_q      <= '0;
      fetch_q    <= '0;
      sta_skip_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tmo_q      <= tmo_d;
      fetch_q    <= fetch_d;
      sta_skip_q <= sta_skip_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef QSPI_XIP_CACHE_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end
`endif

  assign rdata_o = rdata_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qspi_xip_sequencer.sv
// tb/tb_qspi_xip_sequencer.sv - directed self-checking bench with a QSPI master register model
`timescale 1ns/1ps
module tb_qspi_xip_sequencer;

  localparam int TMO = 4096;
`ifdef QSPI_XIP_CACHE_EN
  localparam logic [31:0] EXP_ADR = 32'h20120000;
  localparam logic [31:0] EXP_CCR = 32'h821F236B;
  localparam int          EXP_IDX = 5;
`else
  localparam logic [31:0] EXP_ADR = 32'h34120000;
  localparam logic [31:0] EXP_CCR = 32'h8203236B;
  localparam int          EXP_IDX = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic [23:0] addr_i = 24'h0;
  logic        gnt_o, rvalid_o, err_o, busy_o;
  logic [31:0] rdata_o;
  logic        qspi_write_o;
  logic [3:0]  qspi_be_o;
  logic [5:0]  qspi_addr_o;
  logic [31:0] qspi_wdata_o;
  logic [31:0] qspi_rdata_i = 32'h0;

  int checks = 0;
  int errors = 0;

  logic        stuck = 1'b0;
  int          busy_left = 0;
  logic [31:0] dr_mem [8];

  always #5 clk_i = ~clk_i;

  qspi_xip_sequencer #(.TIMEOUT(TMO)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .busy_o       (busy_o),
    .qspi_write_o (qspi_write_o),
    .qspi_be_o    (qspi_be_o),
    .qspi_addr_o  (qspi_addr_o),
    .qspi_wdata_o (qspi_wdata_o),
    .qspi_rdata_i (qspi_rdata_i)
  );

  function automatic logic [31:0] model_rd(input logic [5:0] a, input int bl, input logic stk);
    if (a == 6'd40) return (stk || bl != 0) ? 32'd2 : 32'd1;
    if (a >= 6'd8 && a <= 6'd36) return dr_mem[(int'(a) - 8) / 4];
    return 32'h0;
  endfunction

  // Master model: STA stays at 2 for five cycles after a CCR start write.
  always @(posedge clk_i) begin
    qspi_rdata_i <= model_rd(qspi_addr_o, busy_left, stuck);
    if (qspi_write_o && qspi_addr_o == 6'd0 && qspi_wdata_o[31]) busy_left <= 5;
    else if (busy_left != 0) busy_left <= busy_left - 1;
  end

  task automatic issue(input logic [23:0] a, output bit got);
    @(negedge clk_i);
    req_i = 1'b1;
    addr_i = a;
    #1;
    for (int i = 0; i < 50 && !gnt_o; i++) begin
      @(negedge clk_i);
      #1;
    end
    got = gnt_o;
  endtask

  task automatic wait_resp(output int n);
    n = -1;
    for (int i = 1; i < 300; i++) begin
      @(negedge clk_i);
      req_i = 1'b0;
      #1;
      if (rvalid_o) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int n;
    rst_ni = 1'b0;
    req_i = 1'b1;
    addr_i = 24'h000010;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if (gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt: got %b want 0", gnt_o);
    end
    checks++;
    if ({rvalid_o, err_o, busy_o, qspi_write_o, qspi_be_o, qspi_addr_o, qspi_wdata_o, rdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rv=%b err=%b busy=%b wr=%b be=%h a=%h wd=%h rd=%h want all 0",
               rvalid_o, err_o, busy_o, qspi_write_o, qspi_be_o, qspi_addr_o, qspi_wdata_o, rdata_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    checks++;
    if (gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_gnt: got %b want 1", gnt_o);
    end
    wait_resp(n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL reset_drain: no rvalid within bound");
    end
  endtask

  task automatic test_miss;
    bit got;
    bit done = 0;
    int rv = 0;
    int be_bad = 0;
    int adr_cyc = -1;
    int ccr_cyc = -1;
    logic [31:0] adr_w = 0, ccr_w = 0, rd = 0;
    logic errv = 0;
    for (int i = 0; i < 8; i++) dr_mem[i] = 32'h11111111 * 32'(i);
    dr_mem[EXP_IDX] = 32'hDEADBEEF;
    issue(24'h001234, got);
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL miss_gnt: got %b want 1", got);
    end
    for (int cyc = 1; cyc < 200 && !done; cyc++) begin
      @(negedge clk_i);
      req_i = 1'b0;
      #1;
      if (qspi_write_o) begin
        if (qspi_be_o !== 4'hF) be_bad++;
        if (qspi_addr_o == 6'd4) begin adr_cyc = cyc; adr_w = qspi_wdata_o; end
        if (qspi_addr_o == 6'd0) begin ccr_cyc = cyc; ccr_w = qspi_wdata_o; end
      end
      if (rvalid_o) begin
        rv++;
        rd = rdata_o;
        errv = err_o;
      end else if (rv != 0) begin
        done = 1;
      end
    end
    checks++;
    if (adr_cyc != 1 || adr_w !== EXP_ADR) begin
      errors++;
      $display("FAIL miss_adr_write: cycle %0d data %h want cycle 1 data %h", adr_cyc, adr_w, EXP_ADR);
    end
    checks++;
    if (ccr_cyc != 2 || ccr_w !== EXP_CCR) begin
      errors++;
      $display("FAIL miss_ccr_write: cycle %0d data %h want cycle 2 data %h", ccr_cyc, ccr_w, EXP_CCR);
    end
    checks++;
    if (be_bad != 0) begin
      errors++;
      $display("FAIL miss_be: %0d writes without be=F, want 0", be_bad);
    end
    checks++;
    if (rv != 1) begin
      errors++;
      $display("FAIL miss_rvalid_width: %0d cycles want 1", rv);
    end
    checks++;
    if (rd !== 32'hDEADBEEF || errv !== 1'b0) begin
      errors++;
      $display("FAIL miss_rdata: rdata %h err %b want deadbeef err 0", rd, errv);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL miss_idle_after: busy %b want 0", busy_o);
    end
  endtask

`ifdef QSPI_XIP_CACHE_EN
  task automatic test_cache;
    bit got;
    int n;
    int dr_reads = 0;
    int wr_seen = 0;
    for (int i = 0; i < 8; i++) dr_mem[i] = 32'hCAFE0000 | 32'(i);
    issue(24'h000040, got);
    for (int i = 1; i < 200; i++) begin
      @(negedge clk_i);
      req_i = 1'b0;
      #1;
      if (!qspi_write_o && qspi_addr_o >= 6'd8 && qspi_addr_o <= 6'd36) dr_reads++;
      if (rvalid_o) break;
    end
    checks++;
    if (dr_reads != 8 || rdata_o !== 32'hCAFE0000) begin
      errors++;
      $display("FAIL cache_fill: dr reads %0d rdata %h want 8 cafe0000", dr_reads, rdata_o);
    end
    issue(24'h000048, got);
    if (qspi_write_o) wr_seen++;
    @(negedge clk_i);
    req_i = 1'b0;
    #1;
    if (qspi_write_o) wr_seen++;
    checks++;
    if (got !== 1'b1 || rvalid_o !== 1'b1 || rdata_o !== 32'hCAFE0002 || wr_seen != 0) begin
      errors++;
      $display("FAIL cache_hit_w2: gnt %b rvalid %b rdata %h writes %0d want 1 1 cafe0002 0",
               got, rvalid_o, rdata_o, wr_seen);
    end
    issue(24'h00005C, got);
    @(negedge clk_i);
    req_i = 1'b0;
    #1;
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'hCAFE0007) begin
      errors++;
      $display("FAIL cache_hit_w7: rvalid %b rdata %h want 1 cafe0007", rvalid_o, rdata_o);
    end
    wait_resp(n);
    checks++;
    if (n != -1) begin
      errors++;
      $display("FAIL cache_no_extra_resp: extra rvalid at %0d want none", n);
    end
  endtask
`endif

  task automatic test_timeout;
    bit got;
    int rv_cyc = -1;
    logic errv = 0;
    logic [31:0] rd = 32'hFFFFFFFF;
    stuck = 1'b1;
    issue(24'h000100, got);
    for (int cyc = 1; cyc < TMO + 20; cyc++) begin
      @(negedge clk_i);
      req_i = 1'b0;
      #1;
      if (rvalid_o) begin
        rv_cyc = cyc;
        errv = err_o;
        rd = rdata_o;
        break;
      end
    end
    stuck = 1'b0;
    checks++;
    if (rv_cyc != TMO + 3) begin
      errors++;
      $display("FAIL timeout_latency: rvalid at cycle %0d want %0d", rv_cyc, TMO + 3);
    end
    checks++;
    if (errv !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL timeout_resp: err %b rdata %h want 1 0", errv, rd);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if (rvalid_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: rvalid %b err %b want 0 0", rvalid_o, err_o);
    end
  endtask

  task automatic test_reset_mid;
    bit got;
    int n;
    int rv = 0;
    stuck = 1'b1;
    issue(24'h000200, got);
    repeat (10) begin
      @(negedge clk_i);
      req_i = 1'b0;
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || rvalid_o !== 1'b0 || qspi_addr_o !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy %b rvalid %b addr %h want 0 0 0", busy_o, rvalid_o, qspi_addr_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    stuck = 1'b0;
    repeat (10) begin
      @(negedge clk_i);
      #1;
      if (rvalid_o) rv++;
    end
    checks++;
    if (rv != 0) begin
      errors++;
      $display("FAIL reset_mid_no_resp: %0d rvalid cycles want 0", rv);
    end
    issue(24'h000300, got);
    @(negedge clk_i);
    req_i = 1'b0;
    #1;
    checks++;
    if (qspi_write_o !== 1'b1 || qspi_addr_o !== 6'd4 || qspi_wdata_o !== 32'h00030000) begin
      errors++;
      $display("FAIL reset_mid_restart: wr %b addr %h data %h want 1 04 00030000",
               qspi_write_o, qspi_addr_o, qspi_wdata_o);
    end
    wait_resp(n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL reset_mid_drain: no rvalid within bound");
    end
  endtask

  task automatic test_back_to_back;
    bit got;
    int n;
    int rv_cyc = -1;
    int g2 = -1;
    issue(24'h000400, got);
    addr_i = 24'h000500;
    for (int cyc = 1; cyc < 200; cyc++) begin
      @(negedge clk_i);
      #1;
      if (rvalid_o && rv_cyc < 0) rv_cyc = cyc;
      if (gnt_o) begin
        g2 = cyc;
        break;
      end
    end
    checks++;
    if (rv_cyc < 0 || g2 != rv_cyc + 1) begin
      errors++;
      $display("FAIL b2b_second_gnt: rvalid cycle %0d second gnt cycle %0d want gnt one after rvalid",
               rv_cyc, g2);
    end
    wait_resp(n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL b2b_second_resp: no rvalid within bound");
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) dr_mem[i] = 32'h0;
    test_reset;
    test_miss;
`ifdef QSPI_XIP_CACHE_EN
    test_cache;
`endif
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
